// File: rtl/bus_pkg.sv
// Shared definitions for the simple write bus and its arbiters.
package bus_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    // Default bus widths
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Base address of the GPIO block on this bus
    localparam logic [31:0] GPIO_BASE = 32'h0000_2000;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker: a lone requester wins; on a tie
// the requester that was not served last wins.
module arb_rr2
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick the winner from the request vector and the last-served index
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arb2.sv
// Two-master, one-slave write-bus arbiter with round-robin selection,
// registered handshakes and a bounded slave timeout.
module bus_arb2
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wstrb,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wstrb,
    output logic              m1_ready,
    output logic              m1_err,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wstrb,
    input  logic              s_ready,
    output logic              busy,
    output logic              grant
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_busy;
    logic                r_grant;
    logic                r_last;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_s_valid;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic                r_s_wstrb;
    logic [1:0]          r_m_ready;
    logic [1:0]          r_m_err;

    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_wstrb;

    arb_rr2 u_pick (
        .req       ({m1_valid, m0_valid}),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Route the winning master's payload toward the capture registers
    always_comb begin
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_wstrb = m0_wstrb;
        if (w_gnt_idx) begin
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_wstrb = m1_wstrb;
        end
    end

    // Arbitration FSM with registered slave request and master responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_tcnt    <= '0;
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_wstrb <= 1'b0;
            r_m_ready <= '0;
            r_m_err   <= '0;
        end else begin
            r_m_ready <= '0;
            r_m_err   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_s_addr  <= w_sel_addr;
                        r_s_wdata <= w_sel_wdata;
                        r_s_wstrb <= w_sel_wstrb;
                        r_s_valid <= 1'b1;
                        r_grant   <= w_gnt_idx;
                        r_busy    <= 1'b1;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Counts up to TIMEOUT at most; DONE clears it before reuse
                    r_tcnt <= r_tcnt + 1'b1;
                    if (s_ready) begin
                        r_s_valid          <= 1'b0;
                        r_m_ready[r_grant] <= 1'b1;
                        r_last             <= r_grant;
                        r_state            <= DONE;
                    end else if (r_tcnt == TCNT_LAST) begin
                        r_s_valid          <= 1'b0;
                        r_m_ready[r_grant] <= 1'b1;
                        r_m_err[r_grant]   <= 1'b1;
                        r_last             <= r_grant;
                        r_state            <= DONE;
                    end
                end
                DONE: begin
                    r_tcnt  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_tcnt    <= '0;
                    r_busy    <= 1'b0;
                    r_s_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign m0_ready = r_m_ready[0];
    assign m1_ready = r_m_ready[1];
    assign m0_err   = r_m_err[0];
    assign m1_err   = r_m_err[1];
    assign s_valid  = r_s_valid;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign busy     = r_busy;
    assign grant    = r_grant;

endmodule
